// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: default sizes,
// count-width helper and the occupancy state encoding.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // An occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: one write port, one registered read port.
// Only the read data register is reset; the array itself is not.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  // NOTE: the array has no reset so it maps onto RAM macros/LUT-RAM; stale
  // contents are never visible because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and
// read-valid strobe. Define FIFO_ERR_EN to enable sticky overflow/underflow flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int CW       = cnt_w(DEPTH),
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_valid_q, rd_valid_d;
  logic          wr_acc, rd_acc;

  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    wr_acc     = wr & ~full & ~rst;
    rd_acc     = rd & ~empty & ~rst;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rd_valid_d = rd_acc;

    // Explicit wrap compare keeps non-power-of-2 depths correct.
    if (wr_acc) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + AW'(1);
    if (rd_acc) rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + AW'(1);

    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr_q),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rptr_q),
    .rdata (dout)
  );

  assign rd_valid = rd_valid_q;
  assign count    = count_q;

`ifdef FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (wr & full);
    underflow_d = underflow_q | (rd & empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a 16-deep instance for the main scenarios
// and a 10-deep instance for non-power-of-2 wrap. Build with FIFO_ERR_EN to check error flags.
module tb_sync_fifo_param;

`ifdef FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, wr, rd;
  logic [7:0] din, dout;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       rst2, wr2, rd2;
  logic [7:0] din2, dout2;
  logic       rd_valid2, full2, empty2, almost_full2, almost_empty2, overflow2, underflow2;
  logic [3:0] count2;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .dout(dout),
    .rd_valid(rd_valid), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(10)) dut10 (
    .clk(clk), .rst(rst2), .wr(wr2), .din(din2), .rd(rd2), .dout(dout2),
    .rd_valid(rd_valid2), .full(full2), .empty(empty2), .almost_full(almost_full2),
    .almost_empty(almost_empty2), .count(count2), .overflow(overflow2), .underflow(underflow2)
  );

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 1'b0; rd = 1'b0; din = '0;
    rst2 = 1'b1; wr2 = 1'b0; rd2 = 1'b0; din2 = '0;
    step();
    step();
    rst = 1'b0; rst2 = 1'b0;
    tests_run++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0 || dout !== 8'h00 ||
        almost_empty !== 1'b1 || almost_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: count=%0d empty=%b full=%b rv=%b dout=%h ae=%b af=%b ovf=%b unf=%b (want 0 1 0 0 00 1 0 0 0)",
               count, empty, full, rd_valid, dout, almost_empty, almost_full, overflow, underflow);
    end
    tests_run++;
    if (count2 !== 4'd0 || empty2 !== 1'b1 || full2 !== 1'b0 || dout2 !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset10: count=%0d empty=%b full=%b dout=%h (want 0 1 0 00)", count2, empty2, full2, dout2);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      wr = 1'b1; din = 8'(i);
      step();
      tests_run++;
      if (count !== 5'(i) || full !== (i == 16) || almost_full !== (i >= 14) ||
          almost_empty !== (i <= 2) || rd_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL fill[%0d]: count=%0d full=%b af=%b ae=%b rv=%b", i, count, full, almost_full, almost_empty, rd_valid);
      end
    end
    din = 8'h55;
    step();
    wr = 1'b0;
    tests_run++;
    if (count !== 5'd16 || full !== 1'b1 || overflow !== ERR_EN) begin
      tests_failed++;
      $display("FAIL fill_drop: count=%0d full=%b ovf=%b (want 16 1 %b)", count, full, overflow, ERR_EN);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      rd = 1'b1;
      step();
      tests_run++;
      if (dout !== 8'(i) || rd_valid !== 1'b1 || count !== 5'(16 - i) || overflow !== ERR_EN) begin
        tests_failed++;
        $display("FAIL drain[%0d]: dout=%h rv=%b count=%0d ovf=%b (want %h 1 %0d %b)",
                 i, dout, rd_valid, count, overflow, 8'(i), 16 - i, ERR_EN);
      end
    end
    step();
    rd = 1'b0;
    tests_run++;
    if (rd_valid !== 1'b0 || dout !== 8'h10 || empty !== 1'b1 || count !== 5'd0 || underflow !== ERR_EN) begin
      tests_failed++;
      $display("FAIL drain_extra: rv=%b dout=%h empty=%b count=%0d unf=%b (want 0 10 1 0 %b)",
               rd_valid, dout, empty, count, underflow, ERR_EN);
    end
  endtask

  task automatic test_concurrent();
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; din = 8'(8'h20 + i);
      step();
    end
    tests_run++;
    if (count !== 5'd5) begin
      tests_failed++;
      $display("FAIL conc_prefill: count=%0d (want 5)", count);
    end
    for (int k = 0; k < 20; k++) begin
      wr = 1'b1; rd = 1'b1; din = 8'(8'h25 + k);
      step();
      tests_run++;
      if (count !== 5'd5 || dout !== 8'(8'h20 + k) || rd_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL conc[%0d]: count=%0d dout=%h rv=%b (want 5 %h 1)", k, count, dout, rd_valid, 8'(8'h20 + k));
      end
    end
    wr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      tests_run++;
      if (dout !== 8'(8'h34 + k) || count !== 5'(4 - k)) begin
        tests_failed++;
        $display("FAIL conc_drain[%0d]: dout=%h count=%0d (want %h %0d)", k, dout, count, 8'(8'h34 + k), 4 - k);
      end
    end
    rd = 1'b0;
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; din = 8'(8'h40 + i);
      step();
    end
    wr = 1'b1; rd = 1'b1; din = 8'h99;
    step();
    tests_run++;
    if (count !== 5'd15 || dout !== 8'h40 || rd_valid !== 1'b1 || full !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_wr_rd: count=%0d dout=%h rv=%b full=%b (want 15 40 1 0)", count, dout, rd_valid, full);
    end
    wr = 1'b0;
    for (int i = 1; i <= 15; i++) step();
    rd = 1'b0;
    tests_run++;
    if (dout !== 8'h4f || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_drain: dout=%h empty=%b (want 4f 1)", dout, empty);
    end
    wr = 1'b1; rd = 1'b1; din = 8'h77;
    step();
    wr = 1'b0; rd = 1'b0;
    tests_run++;
    if (count !== 5'd1 || rd_valid !== 1'b0 || dout !== 8'h4f) begin
      tests_failed++;
      $display("FAIL empty_wr_rd: count=%0d rv=%b dout=%h (want 1 0 4f)", count, rd_valid, dout);
    end
    rd = 1'b1;
    step();
    rd = 1'b0;
    tests_run++;
    if (dout !== 8'h77 || rd_valid !== 1'b1 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_wr_rd_read: dout=%h rv=%b empty=%b (want 77 1 1)", dout, rd_valid, empty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) begin
      wr = 1'b1; din = 8'(8'h60 + i);
      step();
    end
    tests_run++;
    if (count !== 5'd9) begin
      tests_failed++;
      $display("FAIL mid_prefill: count=%0d (want 9)", count);
    end
    rst = 1'b1; wr = 1'b1; rd = 1'b1; din = 8'hee;
    step();
    rst = 1'b0; wr = 1'b0; rd = 1'b0;
    tests_run++;
    if (count !== 5'd0 || empty !== 1'b1 || dout !== 8'h00 || rd_valid !== 1'b0 ||
        overflow !== 1'b0 || underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: count=%0d empty=%b dout=%h rv=%b ovf=%b unf=%b (want 0 1 00 0 0 0)",
               count, empty, dout, rd_valid, overflow, underflow);
    end
    wr = 1'b1; din = 8'ha5; step();
    din = 8'ha6; step();
    wr = 1'b0; rd = 1'b1; step();
    rd = 1'b0;
    tests_run++;
    if (dout !== 8'ha5 || rd_valid !== 1'b1 || count !== 5'd1) begin
      tests_failed++;
      $display("FAIL mid_first_read: dout=%h rv=%b count=%0d (want a5 1 1)", dout, rd_valid, count);
    end
  endtask

  task automatic test_err_flags();
    rd = 1'b1; step();
    tests_run++;
    if (dout !== 8'ha6 || underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_last_read: dout=%h unf=%b (want a6 0)", dout, underflow);
    end
    step();
    rd = 1'b0;
    tests_run++;
    if (underflow !== ERR_EN || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_underflow: unf=%b ovf=%b (want %b 0)", underflow, overflow, ERR_EN);
    end
    wr = 1'b1;
    for (int i = 0; i < 17; i++) begin
      din = 8'(i); step();
    end
    wr = 1'b0; rd = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rd = 1'b0;
    tests_run++;
    if (overflow !== ERR_EN || underflow !== ERR_EN || count !== 5'd13) begin
      tests_failed++;
      $display("FAIL err_sticky: ovf=%b unf=%b count=%0d (want %b %b 13)", overflow, underflow, count, ERR_EN, ERR_EN);
    end
    rst = 1'b1; step();
    rst = 1'b0;
    tests_run++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_clear: ovf=%b unf=%b (want 0 0)", overflow, underflow);
    end
  endtask

  task automatic test_depth10();
    for (int i = 1; i <= 11; i++) begin
      wr2 = 1'b1; din2 = 8'(i);
      step();
      tests_run++;
      if (count2 !== 4'((i > 10) ? 10 : i) || full2 !== (i >= 10) || almost_full2 !== (i >= 8)) begin
        tests_failed++;
        $display("FAIL d10_fill[%0d]: count=%0d full=%b af=%b", i, count2, full2, almost_full2);
      end
    end
    wr2 = 1'b0; rd2 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      tests_run++;
      if (dout2 !== 8'(i) || rd_valid2 !== 1'b1 || count2 !== 4'(10 - i)) begin
        tests_failed++;
        $display("FAIL d10_drain[%0d]: dout=%h rv=%b count=%0d (want %h 1 %0d)", i, dout2, rd_valid2, count2, 8'(i), 10 - i);
      end
    end
    rd2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr2 = 1'b1; din2 = 8'(8'h80 + i); step();
    end
    for (int k = 0; k < 15; k++) begin
      wr2 = 1'b1; rd2 = 1'b1; din2 = 8'(8'h83 + k);
      step();
      tests_run++;
      if (count2 !== 4'd3 || dout2 !== 8'(8'h80 + k)) begin
        tests_failed++;
        $display("FAIL d10_conc[%0d]: count=%0d dout=%h (want 3 %h)", k, count2, dout2, 8'(8'h80 + k));
      end
    end
    wr2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++;
      if (dout2 !== 8'(8'h8f + k)) begin
        tests_failed++;
        $display("FAIL d10_conc_drain[%0d]: dout=%h (want %h)", k, dout2, 8'(8'h8f + k));
      end
    end
    rd2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_concurrent();
    test_boundary();
    test_reset_mid();
    test_err_flags();
    test_depth10();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
